// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer.
// Truth tables are LSB-first: bit k is the expected output for input vector k.
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    localparam int unsigned N_IN_MAX = 6;

    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

    function automatic int unsigned n_vec(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Host/gate-facing signal bundle of the gate sweep sequencer.
// slave = the sequencer, master = host controller plus gate under test.
interface gate_sweep_ctrl_if #(
    parameter int unsigned N_IN = 2
);

    logic            start;
    logic            gate_y;
    logic [N_IN-1:0] gate_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_idx;

    modport master (
        output start,
        output gate_y,
        input  gate_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_idx
    );

    modport slave (
        input  start,
        input  gate_y,
        output gate_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_idx
    );

endinterface

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter timing how long a stimulus vector is held.
// expired is high in the last cycle of the hold interval.
module sweep_settle_timer #(
    parameter int unsigned LOAD_VAL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CW = $clog2(LOAD_VAL + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(LOAD_VAL);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CW'(1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive in-circuit sweep of a combinational gate against a truth table.
// Build option STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned          N_IN          = 2,
    parameter int unsigned          SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH         = TT_AND2
) (
    input logic              clk,
    input logic              rst_n,
    gate_sweep_ctrl_if.slave bus
);

    localparam logic [N_IN-1:0] LAST = N_IN'(n_vec(N_IN) - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] gate_in_q, gate_in_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] fail_q, fail_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_exp;
    logic mismatch;
    logic last_vec;

    sweep_settle_timer #(
        .LOAD_VAL (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expired (tmr_exp)
    );

    assign mismatch = (bus.gate_y != TRUTH[idx_q]);
    assign last_vec = (idx_q == LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gate_in_d = gate_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        fail_d    = fail_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d     = '0;
                    gate_in_d = '0;
                    err_d     = '0;
                    fail_d    = '0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    tmr_load  = 1'b1;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_exp) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        fail_d = idx_q;
                    end
                end
`ifdef STOP_ON_FAIL_EN
                if (last_vec || mismatch) begin
`else
                if (last_vec) begin
`endif
                    state_d = DONE;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    gate_in_d = idx_q + 1'b1;
                    tmr_load  = 1'b1;
                    state_d   = SETTLE;
                end
            end
            DONE: begin
                // err_q already holds the final SAMPLE result here
                done_d    = 1'b1;
                busy_d    = 1'b0;
                pass_d    = (err_q == '0);
                gate_in_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            gate_in_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gate_in_q <= gate_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            fail_q    <= fail_d;
        end
    end

    assign bus.gate_in   = gate_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_idx  = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: 2-input and 3-input instances driven by
// behavioural gate models, checked against an arithmetic sweep model.
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gate_sweep_ctrl_if #(.N_IN(2)) ifa ();
    gate_sweep_ctrl_if #(.N_IN(3)) ifb ();

    logic [3:0] gfun_a = 4'h0;
    logic [7:0] gfun_b = 8'h0;
    logic       glitch_a = 1'b0;
    logic       glitch_b = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       sel = 1'b0;

    assign ifa.start  = start_a;
    assign ifb.start  = start_b;
    assign ifa.gate_y = gfun_a[ifa.gate_in] ^ glitch_a;
    assign ifb.gate_y = gfun_b[ifb.gate_in] ^ glitch_b;

    gate_sweep_ctrl #(
        .N_IN          (2),
        .SETTLE_CYCLES (S),
        .TRUTH         (TT_AND2)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    gate_sweep_ctrl #(
        .N_IN          (3),
        .SETTLE_CYCLES (S),
        .TRUTH         (8'h80)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    wire [2:0] m_gin  = sel ? ifb.gate_in : {1'b0, ifa.gate_in};
    wire       m_busy = sel ? ifb.busy : ifa.busy;
    wire       m_done = sel ? ifb.done : ifa.done;
    wire       m_pass = sel ? ifb.pass : ifa.pass;
    wire [3:0] m_err  = sel ? ifb.err_count : {1'b0, ifa.err_count};
    wire [2:0] m_fail = sel ? ifb.fail_idx : {1'b0, ifa.fail_idx};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected sweep outcome from gate function g and truth table tr.
    function automatic void ref_sweep(input int n, input logic [7:0] tr,
                                      input logic [7:0] g,
                                      output int err, output int fidx,
                                      output int last, output int lat);
        int nv = 1 << n;
        err  = 0;
        fidx = 0;
        last = nv - 1;
        for (int k = 0; k < nv; k++) begin
            if (g[k] !== tr[k]) begin
                if (err == 0) fidx = k;
                err++;
`ifdef STOP_ON_FAIL_EN
                last = k;
                break;
`endif
            end
        end
        lat = (last + 1) * (S + 1) + 1;
    endfunction

    task automatic set_glitch(input logic v);
        if (sel) glitch_b = v;
        else glitch_a = v;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_gin"}, m_gin, 0);
        chk({tag, "_busy"}, m_busy, 0);
        chk({tag, "_done"}, m_done, 0);
        chk({tag, "_pass"}, m_pass, 0);
        chk({tag, "_err"}, m_err, 0);
        chk({tag, "_fail"}, m_fail, 0);
    endtask

    task automatic run(input logic s, input logic [7:0] g,
                       input string tag);
        int n, err, fidx, last, lat, got, ex;
        logic [7:0] tr;
        n   = s ? 3 : 2;
        tr  = s ? 8'h80 : {4'h0, TT_AND2};
        ref_sweep(n, tr, g, err, fidx, last, lat);
        sel = s;
        if (s) gfun_b = g;
        else gfun_a = g[3:0];
        @(negedge clk);
        if (s) start_b = 1'b1;
        else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_gin0"}, m_gin, 0);
        chk({tag, "_busy0"}, m_busy, 1);
        set_glitch(1'($urandom));
        got = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (m_done) begin
                got = c;
                break;
            end
            ex = c / (S + 1);
            if (ex > last) ex = last;
            chk({tag, "_gin"}, m_gin, ex);
            chk({tag, "_busy"}, m_busy, 1);
            set_glitch((c % (S + 1) != S) ? 1'($urandom) : 1'b0);
        end
        set_glitch(1'b0);
        chk({tag, "_lat"}, got, lat);
        if (got != -1) begin
            chk({tag, "_gin_end"}, m_gin, 0);
            chk({tag, "_busy_end"}, m_busy, 0);
        end
        chk({tag, "_err"}, m_err, err);
        chk({tag, "_fail"}, m_fail, fidx);
        chk({tag, "_pass"}, m_pass, (err == 0));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, m_done, 0);
    endtask

    initial begin
        int exp_q[$];
        int got_q[$];
        int ndone;
        int at;
        logic found;

        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        #1;
        check_idle_zero("rst_a");
        sel = 1'b1;
        #1;
        check_idle_zero("rst_b");
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b0, 8'h08, "and2");
        run(1'b0, 8'h00, "stuck0");
        run(1'b0, 8'h0E, "or2");
        run(1'b0, 8'h06, "xor2");
        for (int i = 0; i < 6; i++) begin
            run(1'b0, 8'($urandom_range(0, 15)), "rnd2");
        end

        // start held high: back-to-back sweeps
        sel = 1'b0;
        gfun_a = 4'b1000;
        exp_q.delete();
        got_q.delete();
        for (int a = 0; a <= 39; a += 14) exp_q.push_back(a + 13);
        @(negedge clk);
        start_a = 1'b1;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk);
            #1;
            if (m_done) got_q.push_back(e);
            if (e == 39) start_a = 1'b0;
        end
        chk("hold_cnt", got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            at = (i < got_q.size()) ? got_q[i] : -1;
            chk("hold_at", at, exp_q[i]);
        end

        // start pulses while busy or in DONE are ignored
        ndone = 0;
        at = -1;
        @(negedge clk);
        start_a = 1'b1;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (m_done) begin
                ndone++;
                at = e;
            end
            start_a = (e == 2 || e == 6 || e == 11);
        end
        chk("ign_cnt", ndone, 1);
        chk("ign_at", at, 13);

        // reset in the middle of a sweep
        sel = 1'b0;
        gfun_a = 4'b1000;
        found = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (m_gin == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_reach", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_rst");
        ndone = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            if (m_done) ndone++;
        end
        chk("mid_nodone", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 8'h08, "after_rst");

        run(1'b1, 8'h80, "and3");
        for (int i = 0; i < 3; i++) begin
            run(1'b1, 8'($urandom), "rnd3");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
